// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, requester ids and
// the request bundle at the default RAM geometry.
package ram_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_IFETCH = 1'b0;
    localparam port_id_t PORT_DATA   = 1'b1;

    localparam int unsigned REQ_ADDR_WIDTH = 10;
    localparam int unsigned REQ_DATA_WIDTH = 32;
    localparam int unsigned REQ_NB_COL     = 4;

    typedef struct packed {
        logic [REQ_NB_COL-1:0]     we;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// Combinational two-way round-robin grant. A set mask bit removes that
// requester from consideration entirely.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  port_id_t   last_gnt_i,
    output logic [1:0] gnt_o
);

    logic [1:0] elig;

    assign elig = req_i & ~mask_i;

    always_comb begin
        gnt_o = elig;
        // On a tie the port that did not win last time goes first.
        if (elig == 2'b11) begin
            gnt_o = (last_gnt_i == PORT_IFETCH) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port byte-write RAM between instruction fetch (port 0) and
// the load/store unit (port 1), with a port-1 lock for atomic sequences.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NB_COL     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_req_i,
    input  logic [NB_COL-1:0]     m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic [NB_COL-1:0]     m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic                  m1_lock_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic [NB_COL-1:0]     ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    arb_state_e            state_q, state_d;
    port_id_t              last_gnt_q, last_gnt_d;
    logic                  rsp_pending_q, rsp_pending_d;
    port_id_t              rsp_owner_q, rsp_owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [1:0]            gnt_raw;
    logic [1:0]            gnt;
    logic [1:0]            mask;
    logic                  gnt_any;
    port_id_t              sel;
    logic [NB_COL-1:0]     sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [1:0]            rvalid;
    logic [DATA_WIDTH-1:0] rdata_port [2];

    assign mask = (state_q == LOCKED) ? 2'b01 : 2'b00;

    rr_arbiter_2 u_rr (
        .req_i      ({m1_req_i, m0_req_i}),
        .mask_i     (mask),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt_raw)
    );

    // Grants are combinational, so they must be forced off while reset is held.
    assign gnt       = rst_i ? 2'b00 : gnt_raw;
    assign gnt_any   = |gnt;
    assign sel       = gnt[1] ? PORT_DATA : PORT_IFETCH;
    assign sel_we    = (sel == PORT_DATA) ? m1_we_i    : m0_we_i;
    assign sel_addr  = (sel == PORT_DATA) ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = (sel == PORT_DATA) ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign ram_we_o    = gnt_any ? sel_we    : '0;
    assign ram_addr_o  = gnt_any ? sel_addr  : addr_q;
    assign ram_wdata_o = gnt_any ? sel_wdata : wdata_q;

    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        rsp_pending_d = gnt_any;
        rsp_owner_d   = rsp_owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;

        if (gnt_any) begin
            last_gnt_d  = sel;
            rsp_owner_d = sel;
            addr_d      = sel_addr;
            wdata_d     = sel_wdata;
        end

        case (state_q)
            ARB: begin
                if (gnt[1] && m1_lock_i) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!m1_lock_i) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ARB;
            last_gnt_q    <= PORT_DATA;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= PORT_IFETCH;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_gnt_q    <= last_gnt_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    // Read data is steered to the owner of the previous grant and zeroed elsewhere.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rvalid[gi]     = rsp_pending_q && (rsp_owner_q == port_id_t'(gi));
        assign rdata_port[gi] = rvalid[gi] ? ram_rdata_i : '0;
    end

    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_rdata_o  = rdata_port[0];
    assign m1_rdata_o  = rdata_port[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, hand-built
// lock/fairness/reset sequences, then random traffic against a reference model.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req, m1_req, m1_lock;
    logic [NC-1:0] m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [NC-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_COL(NC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m1_lock_i   (m1_lock),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    // Write-first byte-write RAM with one cycle of read latency.
    logic [DW-1:0] tb_mem [1 << AW];
    always @(posedge clk) begin : ram_model
        logic [DW-1:0] w;
        w = tb_mem[ram_addr];
        for (int b = 0; b < NC; b++) begin
            if (ram_we[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
        end
        tb_mem[ram_addr] = w;
        ram_rdata <= w;
    end

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {16'hC0DE, 6'h00, a};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic q0, input ram_req_t r0, input logic q1,
                         input ram_req_t r1, input logic lk);
        m0_req   = q0;
        m0_we    = r0.we;
        m0_addr  = r0.addr;
        m0_wdata = r0.wdata;
        m1_req   = q1;
        m1_we    = r1.we;
        m1_addr  = r1.addr;
        m1_wdata = r1.wdata;
        m1_lock  = lk;
    endtask

    function automatic ram_req_t rq(input logic [3:0] we, input logic [9:0] a,
                                    input logic [31:0] d);
        ram_req_t r;
        r.we    = we;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    task automatic idle();
        drive(1'b0, rq(4'h0, 10'h000, 32'h0), 1'b0, rq(4'h0, 10'h000, 32'h0), 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic          q0;
        ram_req_t      r0;
        logic          q1;
        ram_req_t      r1;
        logic          lk;
        logic          g0, g1, v0, v1;
        logic          c0, c1;
        logic [31:0]   d0, d1;
        logic [NC-1:0] xwe;
        logic [AW-1:0] xaddr;
    } vec_t;

    function automatic vec_t mk(input logic q0, input ram_req_t r0, input logic q1,
                                input ram_req_t r1, input logic lk,
                                input logic g0, input logic g1, input logic v0, input logic v1,
                                input logic c0, input logic c1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [3:0] xwe, input logic [9:0] xaddr);
        vec_t v;
        v.q0 = q0; v.r0 = r0; v.q1 = q1; v.r1 = r1; v.lk = lk;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.c0 = c0; v.c1 = c1; v.d0 = d0; v.d1 = d1;
        v.xwe = xwe; v.xaddr = xaddr;
        return v;
    endfunction

    vec_t vecs [8];

    // Reference model state for the random phase.
    logic [DW-1:0] gold [1 << AW];

    initial begin
        ram_req_t z;
        z = rq(4'h0, 10'h000, 32'h0);
        for (int i = 0; i < (1 << AW); i++) tb_mem[i] = pattern(10'(i));
        tb_mem[10'h010] = 32'hDEADBEEF;
        tb_mem[10'h020] = 32'hAAAAAAAA;

        vecs[0] = mk(1, rq(4'h0, 10'h010, 0), 0, z, 0, 1, 0, 0, 0, 1, 1, 0, 0, 4'h0, 10'h010);
        vecs[1] = mk(0, z, 0, z, 0, 0, 0, 1, 0, 1, 1, 32'hDEADBEEF, 0, 4'h0, 10'h010);
        vecs[2] = mk(0, z, 1, rq(4'b0011, 10'h020, 32'h12345678), 0,
                     0, 1, 0, 0, 1, 1, 0, 0, 4'b0011, 10'h020);
        vecs[3] = mk(0, z, 1, rq(4'h0, 10'h020, 0), 0, 0, 1, 0, 1, 1, 0, 0, 0, 4'h0, 10'h020);
        vecs[4] = mk(0, z, 0, z, 0, 0, 0, 0, 1, 1, 1, 0, 32'hAAAA5678, 4'h0, 10'h020);
        vecs[5] = mk(1, rq(4'hF, 10'h040, 32'h11111111), 1, rq(4'h0, 10'h040, 0), 0,
                     1, 0, 0, 0, 1, 1, 0, 0, 4'hF, 10'h040);
        vecs[6] = mk(0, z, 1, rq(4'h0, 10'h040, 0), 0, 0, 1, 1, 0, 0, 1, 0, 0, 4'h0, 10'h040);
        vecs[7] = mk(0, z, 0, z, 0, 0, 0, 0, 1, 1, 1, 0, 32'h11111111, 4'h0, 10'h040);

        // Reset state: outputs zero even with requests asserted.
        idle();
        m0_req = 1'b1;
        m1_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_m0_gnt", m0_gnt, 1'b0);
        chk1("reset_m1_gnt", m1_gnt, 1'b0);
        chk1("reset_m0_rvalid", m0_rvalid, 1'b0);
        chk1("reset_m1_rvalid", m1_rvalid, 1'b0);
        chk32("reset_ram_addr", 32'(ram_addr), 32'h0);
        chk32("reset_ram_we", 32'(ram_we), 32'h0);
        chk32("reset_ram_wdata", ram_wdata, 32'h0);
        do_reset();

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].q0, vecs[i].r0, vecs[i].q1, vecs[i].r1, vecs[i].lk);
            #1;
            $display("vec %0d: gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h",
                     i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata);
            chk1($sformatf("vec%0d_m0_gnt", i), m0_gnt, vecs[i].g0);
            chk1($sformatf("vec%0d_m1_gnt", i), m1_gnt, vecs[i].g1);
            chk1($sformatf("vec%0d_m0_rvalid", i), m0_rvalid, vecs[i].v0);
            chk1($sformatf("vec%0d_m1_rvalid", i), m1_rvalid, vecs[i].v1);
            if (vecs[i].c0) chk32($sformatf("vec%0d_m0_rdata", i), m0_rdata, vecs[i].d0);
            if (vecs[i].c1) chk32($sformatf("vec%0d_m1_rdata", i), m1_rdata, vecs[i].d1);
            chk32($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].xwe));
            chk32($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].xaddr));
            step();
        end

        // Fairness: both ports request continuously.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drive(1, rq(4'h0, 10'h050, 0), 1, rq(4'h0, 10'h060, 0), 0);
            else idle();
            #1;
            $display("fair %0d: gnt=%b%b rvalid=%b%b", k, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
            chk1($sformatf("fair%0d_m0_gnt", k), m0_gnt, (k < 8) && (k % 2 == 0));
            chk1($sformatf("fair%0d_m1_gnt", k), m1_gnt, (k < 8) && (k % 2 == 1));
            if (k > 0) begin
                chk1($sformatf("fair%0d_m0_rvalid", k), m0_rvalid, ((k - 1) % 2 == 0));
                chk1($sformatf("fair%0d_m1_rvalid", k), m1_rvalid, ((k - 1) % 2 == 1));
                if ((k - 1) % 2 == 0) begin
                    chk32($sformatf("fair%0d_m0_rdata", k), m0_rdata, pattern(10'h050));
                    chk32($sformatf("fair%0d_m1_rdata", k), m1_rdata, 32'h0);
                end else begin
                    chk32($sformatf("fair%0d_m1_rdata", k), m1_rdata, pattern(10'h060));
                    chk32($sformatf("fair%0d_m0_rdata", k), m0_rdata, 32'h0);
                end
            end
            step();
        end

        // Locked read-modify-write on port 1 while port 0 waits.
        drive(0, z, 1, rq(4'h0, 10'h030, 0), 1);
        #1;
        $display("lock 0: gnt=%b%b", m1_gnt, m0_gnt);
        chk1("lock0_m1_gnt", m1_gnt, 1'b1);
        step();
        drive(1, rq(4'h0, 10'h070, 0), 1, rq(4'hF, 10'h030, 32'h5A5A0030), 1);
        #1;
        $display("lock 1: gnt=%b%b rdata1=%h", m1_gnt, m0_gnt, m1_rdata);
        chk1("lock1_m0_gnt", m0_gnt, 1'b0);
        chk1("lock1_m1_gnt", m1_gnt, 1'b1);
        chk1("lock1_m1_rvalid", m1_rvalid, 1'b1);
        chk32("lock1_m1_rdata", m1_rdata, pattern(10'h030));
        step();
        drive(1, rq(4'h0, 10'h070, 0), 0, z, 1);
        #1;
        $display("lock 2: gnt=%b%b", m1_gnt, m0_gnt);
        chk1("lock2_m0_gnt", m0_gnt, 1'b0);
        chk1("lock2_m1_rvalid", m1_rvalid, 1'b1);
        step();
        drive(1, rq(4'h0, 10'h070, 0), 0, z, 0);
        #1;
        $display("lock 3: gnt=%b%b", m1_gnt, m0_gnt);
        chk1("lock3_m0_gnt", m0_gnt, 1'b0);
        step();
        #1;
        $display("lock 4: gnt=%b%b", m1_gnt, m0_gnt);
        chk1("lock4_m0_gnt", m0_gnt, 1'b1);
        step();
        drive(0, z, 1, rq(4'h0, 10'h030, 0), 0);
        #1;
        $display("lock 5: gnt=%b%b rdata0=%h", m1_gnt, m0_gnt, m0_rdata);
        chk1("lock5_m1_gnt", m1_gnt, 1'b1);
        chk1("lock5_m0_rvalid", m0_rvalid, 1'b1);
        chk32("lock5_m0_rdata", m0_rdata, pattern(10'h070));
        step();
        idle();
        #1;
        $display("lock 6: rvalid=%b%b rdata1=%h", m1_rvalid, m0_rvalid, m1_rdata);
        chk1("lock6_m1_rvalid", m1_rvalid, 1'b1);
        chk32("lock6_m1_rdata", m1_rdata, 32'h5A5A0030);
        step();

        // Reset right after a grant drops the pending response.
        drive(1, rq(4'h0, 10'h010, 0), 0, z, 0);
        #1;
        chk1("rst_seq_m0_gnt", m0_gnt, 1'b1);
        step();
        rst = 1'b1;
        drive(1, rq(4'hF, 10'h011, 32'hFFFFFFFF), 1, rq(4'hF, 10'h012, 32'hFFFFFFFF), 1);
        #1;
        $display("rst mid: gnt=%b%b rvalid=%b%b rdata0=%h", m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m0_rdata);
        chk1("rst_mid_m0_rvalid", m0_rvalid, 1'b0);
        chk32("rst_mid_m0_rdata", m0_rdata, 32'h0);
        chk1("rst_mid_m0_gnt", m0_gnt, 1'b0);
        chk1("rst_mid_m1_gnt", m1_gnt, 1'b0);
        chk32("rst_mid_ram_we", 32'(ram_we), 32'h0);
        chk32("rst_mid_ram_addr", 32'(ram_addr), 32'h0);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk1("rst_rel_m0_rvalid", m0_rvalid, 1'b0);
        chk1("rst_rel_m1_rvalid", m1_rvalid, 1'b0);
        step();
        drive(1, rq(4'h0, 10'h050, 0), 1, rq(4'h0, 10'h060, 0), 0);
        #1;
        $display("rst tie: gnt=%b%b", m1_gnt, m0_gnt);
        chk1("rst_tie_m0_gnt", m0_gnt, 1'b1);
        chk1("rst_tie_m1_gnt", m1_gnt, 1'b0);
        step();

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < (1 << AW); i++) gold[i] = tb_mem[i];
        begin
            bit            locked, rv, rrd, p0, p1, lk;
            int            last, rown, w;
            logic [DW-1:0] rdat;
            logic [AW-1:0] hold_addr;
            ram_req_t      q0r, q1r, g;
            locked = 0; rv = 0; rrd = 0; p0 = 0; p1 = 0; lk = 0;
            last = 1; rown = 0; rdat = '0; hold_addr = '0;
            q0r = z; q1r = z;
            for (int c = 0; c < 3000; c++) begin
                if (!p0) begin
                    p0 = ($urandom_range(0, 2) != 0);
                    q0r = rq(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                             10'h100 + 10'($urandom_range(0, 15)), $urandom);
                end
                if (!p1) begin
                    p1 = ($urandom_range(0, 2) != 0);
                    q1r = rq(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                             10'h100 + 10'($urandom_range(0, 15)), $urandom);
                end
                if ($urandom_range(0, 5) == 0) lk = ~lk;
                drive(p0, q0r, p1, q1r, lk);
                #1;
                if (p0 && !locked && p1) w = (last == 0) ? 1 : 0;
                else if (p0 && !locked)  w = 0;
                else if (p1)             w = 1;
                else                     w = -1;
                g = (w == 1) ? q1r : q0r;
                chk1("rnd_m0_gnt", m0_gnt, w == 0);
                chk1("rnd_m1_gnt", m1_gnt, w == 1);
                chk1("rnd_m0_rvalid", m0_rvalid, rv && rown == 0);
                chk1("rnd_m1_rvalid", m1_rvalid, rv && rown == 1);
                if (!(rv && rown == 0)) chk32("rnd_m0_rdata_idle", m0_rdata, 32'h0);
                else if (rrd)           chk32("rnd_m0_rdata", m0_rdata, rdat);
                if (!(rv && rown == 1)) chk32("rnd_m1_rdata_idle", m1_rdata, 32'h0);
                else if (rrd)           chk32("rnd_m1_rdata", m1_rdata, rdat);
                chk32("rnd_ram_we", 32'(ram_we), (w >= 0) ? 32'(g.we) : 32'h0);
                chk32("rnd_ram_addr", 32'(ram_addr), (w >= 0) ? 32'(g.addr) : 32'(hold_addr));
                if (w >= 0) begin
                    for (int b = 0; b < NC; b++) begin
                        if (g.we[b]) gold[g.addr][b*8 +: 8] = g.wdata[b*8 +: 8];
                    end
                    rv = 1; rown = w; rrd = (g.we == 4'h0); rdat = gold[g.addr];
                    last = w; hold_addr = g.addr;
                    if (w == 0) p0 = 0; else p1 = 0;
                end else begin
                    rv = 0;
                end
                if (!locked) locked = (w == 1) && lk;
                else         locked = lk;
                step();
            end
        end
        $display("random: %0d cycles done", 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
